// File: rtl/ps2_paddle_keys_if.sv
// Scancode byte stream from the PS/2 receiver: one byte per key_pressed strobe.
interface ps2_paddle_keys_if;
  logic [7:0] key_data;
  logic       key_pressed;

  modport master (output key_data, output key_pressed);
  modport slave  (input  key_data, input  key_pressed);
endinterface

// File: rtl/ps2_paddle_keys.sv
// Set-2 scancode decoder producing Pong held levels, rate-limited paddle strobes and serve.
// Define PADDLE_KEYS_PAUSE_EN to map P (4D) as a pause toggle; otherwise paused is tied low.
module ps2_paddle_keys #(
  parameter int unsigned MOVE_DIV       = 500000,
  parameter int unsigned PREFIX_TIMEOUT = 2000000
) (
  input  logic             inclock,
  input  logic             resetn,
  ps2_paddle_keys_if.slave key_bus,
  output logic             l_up_held,
  output logic             l_dn_held,
  output logic             r_up_held,
  output logic             r_dn_held,
  output logic             l_move_up,
  output logic             l_move_dn,
  output logic             r_move_up,
  output logic             r_move_dn,
  output logic             serve,
  output logic             paused
);

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DN    = 8'h72;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  localparam logic [23:0] TMO_LAST  = 24'(PREFIX_TIMEOUT - 1);
  localparam logic [23:0] MOVE_LAST = 24'(MOVE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } dec_state_t;

  dec_state_t  state;
  dec_state_t  state_next;
  logic [23:0] tmo_cnt;
  logic        make_std;
  logic        break_std;
  logic        make_ext;
  logic        break_ext;
  logic        space_held;
  logic        serve_q;
  logic [7:0]  code;

  assign code = key_bus.key_data;

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Prefix bytes only steer the state; the byte after them is the key being made or broken.
  always_comb begin
    state_next = state;
    make_std   = 1'b0;
    break_std  = 1'b0;
    make_ext   = 1'b0;
    break_ext  = 1'b0;
    if (key_bus.key_pressed) begin
      case (state)
        IDLE: begin
          if (code == CODE_BREAK) begin
            state_next = BREAK;
          end else if (code == CODE_EXT) begin
            state_next = EXT;
          end else begin
            make_std = 1'b1;
          end
        end
        BREAK: begin
          break_std  = 1'b1;
          state_next = IDLE;
        end
        EXT: begin
          if (code == CODE_BREAK) begin
            state_next = EXT_BREAK;
          end else if (code == CODE_EXT) begin
            state_next = EXT;
          end else begin
            make_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        EXT_BREAK: begin
          break_ext  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
    end else if (key_bus.key_pressed || state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 24'd1;
    end
  end

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      l_up_held  <= 1'b0;
      l_dn_held  <= 1'b0;
      r_up_held  <= 1'b0;
      r_dn_held  <= 1'b0;
      space_held <= 1'b0;
      serve_q    <= 1'b0;
    end else begin
      if (make_std && code == CODE_W) begin
        l_up_held <= 1'b1;
      end else if (break_std && code == CODE_W) begin
        l_up_held <= 1'b0;
      end
      if (make_std && code == CODE_S) begin
        l_dn_held <= 1'b1;
      end else if (break_std && code == CODE_S) begin
        l_dn_held <= 1'b0;
      end
      if (make_ext && code == CODE_UP) begin
        r_up_held <= 1'b1;
      end else if (break_ext && code == CODE_UP) begin
        r_up_held <= 1'b0;
      end
      if (make_ext && code == CODE_DN) begin
        r_dn_held <= 1'b1;
      end else if (break_ext && code == CODE_DN) begin
        r_dn_held <= 1'b0;
      end
      // Typematic repeats arrive as makes while already held, so only a fresh press serves.
      serve_q <= make_std && code == CODE_SPACE && !space_held;
      if (make_std && code == CODE_SPACE) begin
        space_held <= 1'b1;
      end else if (break_std && code == CODE_SPACE) begin
        space_held <= 1'b0;
      end
    end
  end

`ifdef PADDLE_KEYS_PAUSE_EN
  localparam logic [7:0] CODE_P = 8'h4D;
  logic p_held;

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      p_held <= 1'b0;
      paused <= 1'b0;
    end else if (make_std && code == CODE_P) begin
      p_held <= 1'b1;
      if (!p_held) begin
        paused <= ~paused;
      end
    end else if (break_std && code == CODE_P) begin
      p_held <= 1'b0;
    end
  end
`else
  assign paused = 1'b0;
`endif

  assign serve = serve_q & ~paused;

  logic [1:0]  pad_up;
  logic [1:0]  pad_dn;
  logic [1:0]  pad_act;
  logic [1:0]  up_stb_q;
  logic [1:0]  dn_stb_q;
  logic [23:0] move_cnt [2];

  assign pad_up  = {r_up_held, l_up_held};
  assign pad_dn  = {r_dn_held, l_dn_held};
  assign pad_act = (pad_up ^ pad_dn) & {2{~paused}};

  // Index 0 is the left paddle, index 1 the right; the count restarts from 0 whenever a paddle goes idle.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        move_cnt[i] <= '0;
        up_stb_q[i] <= 1'b0;
        dn_stb_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!pad_act[i]) begin
          move_cnt[i] <= '0;
          up_stb_q[i] <= 1'b0;
          dn_stb_q[i] <= 1'b0;
        end else begin
          move_cnt[i] <= (move_cnt[i] == MOVE_LAST) ? 24'd0 : move_cnt[i] + 24'd1;
          up_stb_q[i] <= (move_cnt[i] == 24'd0) && pad_up[i];
          dn_stb_q[i] <= (move_cnt[i] == 24'd0) && pad_dn[i];
        end
      end
    end
  end

  // Gating with the current activity kills a registered strobe on the very cycle a key releases.
  assign l_move_up = up_stb_q[0] & pad_act[0] & pad_up[0];
  assign l_move_dn = dn_stb_q[0] & pad_act[0] & pad_dn[0];
  assign r_move_up = up_stb_q[1] & pad_act[1] & pad_up[1];
  assign r_move_dn = dn_stb_q[1] & pad_act[1] & pad_dn[1];

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Randomized bench for ps2_paddle_keys against a byte-sequence reference model.
// Pause checks are active when PADDLE_KEYS_PAUSE_EN is defined.
module tb_ps2_paddle_keys;

  localparam int MOVE_DIV       = 8;
  localparam int PREFIX_TIMEOUT = 16;

  logic inclock = 1'b0;
  logic resetn  = 1'b0;
  logic l_up_held, l_dn_held, r_up_held, r_dn_held;
  logic l_move_up, l_move_dn, r_move_up, r_move_dn;
  logic serve, paused;

  ps2_paddle_keys_if key_if ();

  ps2_paddle_keys #(
    .MOVE_DIV       (MOVE_DIV),
    .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
  ) dut (
    .inclock   (inclock),
    .resetn    (resetn),
    .key_bus   (key_if),
    .l_up_held (l_up_held),
    .l_dn_held (l_dn_held),
    .r_up_held (r_up_held),
    .r_dn_held (r_dn_held),
    .l_move_up (l_move_up),
    .l_move_dn (l_move_dn),
    .r_move_up (r_move_up),
    .r_move_dn (r_move_dn),
    .serve     (serve),
    .paused    (paused)
  );

  always #5 inclock = ~inclock;

  int total = 0;
  int bad   = 0;

  // Reference model: which codes are held, pending prefix bytes, and per-paddle run lengths.
  bit         std_held [256];
  bit         ext_held [256];
  logic [7:0] seq [$];
  int         gap;
  bit         m_paused;
  bit         serve_now;
  int         run_len [2];
  bit         prev_act [2];
  bit         exp_up [2];
  bit         exp_dn [2];

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h want %h", tag, $time, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      std_held[i] = 1'b0;
      ext_held[i] = 1'b0;
    end
    seq.delete();
    gap       = 0;
    m_paused  = 1'b0;
    serve_now = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_len[i]  = 0;
      prev_act[i] = 1'b0;
      exp_up[i]   = 1'b0;
      exp_dn[i]   = 1'b0;
    end
  endtask

  task automatic std_make(input logic [7:0] d);
    if (d == 8'h29 && !std_held[8'h29]) serve_now = 1'b1;
`ifdef PADDLE_KEYS_PAUSE_EN
    if (d == 8'h4D && !std_held[8'h4D]) m_paused = !m_paused;
`endif
    std_held[d] = 1'b1;
  endtask

  task automatic decode(input logic [7:0] d);
    if (seq.size() == 0) begin
      if (d == 8'hF0 || d == 8'hE0) seq.push_back(d);
      else std_make(d);
    end else if (seq[0] == 8'hF0) begin
      std_held[d] = 1'b0;
      seq.delete();
    end else if (seq.size() == 1) begin
      if (d == 8'hF0) seq.push_back(d);
      else if (d != 8'hE0) begin
        ext_held[d] = 1'b1;
        seq.delete();
      end
    end else begin
      ext_held[d] = 1'b0;
      seq.delete();
    end
  endtask

  task automatic model_step(input logic kp, input logic [7:0] d);
    bit up, dn, act, stb;
    serve_now = 1'b0;
    if (kp) begin
      gap = 0;
      decode(d);
    end else if (seq.size() != 0) begin
      gap++;
      if (gap >= PREFIX_TIMEOUT) seq.delete();
    end
    for (int i = 0; i < 2; i++) begin
      up  = (i == 0) ? std_held[8'h1D] : ext_held[8'h75];
      dn  = (i == 0) ? std_held[8'h1B] : ext_held[8'h72];
      act = (up ^ dn) && !m_paused;
      stb = act && prev_act[i] && (((run_len[i] - 1) % MOVE_DIV) == 0);
      exp_up[i]   = stb && up;
      exp_dn[i]   = stb && dn;
      run_len[i]  = act ? run_len[i] + 1 : 0;
      prev_act[i] = act;
    end
  endtask

  task automatic compare_all();
    checkOutput("held", 16'({r_dn_held, r_up_held, l_dn_held, l_up_held}),
                16'({ext_held[8'h72], ext_held[8'h75], std_held[8'h1B], std_held[8'h1D]}));
    checkOutput("move", 16'({r_move_dn, r_move_up, l_move_dn, l_move_up}),
                16'({exp_dn[1], exp_up[1], exp_dn[0], exp_up[0]}));
    checkOutput("serve", 16'(serve), 16'(serve_now && !m_paused));
    checkOutput("paused", 16'(paused), 16'(m_paused));
  endtask

  // Called #1 after an edge: present one cycle of input, clock it, then check the model.
  task automatic applyStimulus(input logic kp, input logic [7:0] d);
    key_if.key_pressed = kp;
    key_if.key_data    = kp ? d : 8'($urandom);
    @(posedge inclock);
    #1;
    model_step(kp, d);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d);
    applyStimulus(1'b1, d);
  endtask

  logic [7:0] pool [10] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'h4D, 8'hF0, 8'hE0, 8'hF0, 8'hE0};

  initial begin
    int r;
    key_if.key_pressed = 1'b0;
    key_if.key_data    = 8'h00;
    model_reset();
    #12;
    compare_all();
    @(posedge inclock);
    #1;
    resetn = 1'b1;

    // Left up: hold, strobe cadence, release.
    send(8'h1D); idle(20);
    send(8'hF0); send(8'h1D); idle(5);
    // Extended right up, and E0 1D must not touch W.
    send(8'hE0); send(8'h75); idle(10);
    send(8'hE0); send(8'hF0); send(8'h75); idle(3);
    send(8'hE0); send(8'h1D); idle(3);
    // Opposing keys cancel; releasing one resumes at once.
    send(8'h1D); send(8'h1B); idle(12);
    send(8'hF0); send(8'h1B); idle(12);
    // Typematic Space serves once; release and press serves again.
    send(8'h29); send(8'h29); send(8'h29); idle(2);
    send(8'hF0); send(8'h29); send(8'h29); idle(2);
    // Prefix timeout boundary with W held: 15 idle keeps the break, 16 aborts it.
    send(8'hF0); idle(PREFIX_TIMEOUT); send(8'h1D); idle(4);
    send(8'hF0); idle(PREFIX_TIMEOUT - 1); send(8'h1D); idle(4);
    send(8'hF0); idle(PREFIX_TIMEOUT + 3); send(8'h1D); idle(4);
`ifdef PADDLE_KEYS_PAUSE_EN
    send(8'h4D); idle(12);
    send(8'h29); idle(2);
    send(8'hF0); send(8'h4D); send(8'h4D); idle(12);
    send(8'hF0); send(8'h4D); idle(2);
`endif

    // Asynchronous reset in the middle of an E0 prefix.
    send(8'hE0);
    key_if.key_pressed = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge inclock);
    #1;
    resetn = 1'b1;
    compare_all();
    send(8'h1D); idle(10);

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 11);
      send((r < 10) ? pool[r] : 8'($urandom));
      if ($urandom_range(0, 39) == 0) idle(PREFIX_TIMEOUT + 2);
      else idle($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
